// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side observer for a hex-digit 7-segment display bus.
// The active-low segment bus is asynchronous to clk. The block synchronizes
// it, rejects glitches, decodes each stable pattern to a hex digit, checks
// that successive digits step by +1 mod 16, and reports the clk-cycle
// interval between accepted digits.
//
// Optional feature: define SEG7_MON_HIST_EN to add a per-digit histogram
// (ports hist_sel / hist_cnt). When it is undefined those ports and the
// histogram logic are absent.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  segment bus, bit0=a .. bit6=g, active-low, asynchronous
//   digit[3:0]   last accepted decoded digit
//   digit_valid  one-cycle pulse when a new table digit is accepted
//   pattern_err  one-cycle pulse when a non-table, non-blank pattern is accepted
//   seq_err      one-cycle pulse with digit_valid when digit != previous+1 mod 16
//   interval     clk cycles between the previous and the current accepted digit
//   locked       high while tracking a digit sequence
//   hist_sel     (SEG7_MON_HIST_EN) digit whose histogram count is read
//   hist_cnt     (SEG7_MON_HIST_EN) registered count for hist_sel
module seg7_monitor #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] interval,
  output logic             locked
`ifdef SEG7_MON_HIST_EN
  ,
  input  logic [3:0]       hist_sel,
  output logic [15:0]      hist_cnt
`endif
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned STAB_W = 8;
  localparam int unsigned HIST_W = 16;
  localparam int unsigned NDIG   = 16;

  localparam logic [SEG_W-1:0]  BLANK    = 7'h7F;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Decoded result: {hit, digit}; hit is 0 for any pattern outside the table.
  function automatic logic [DIG_W:0] decode(input logic [SEG_W-1:0] pat);
    logic [DIG_W:0] res;
    res = '0;
    unique case (pat)
      7'h40: res = {1'b1, 4'h0};
      7'h79: res = {1'b1, 4'h1};
      7'h24: res = {1'b1, 4'h2};
      7'h30: res = {1'b1, 4'h3};
      7'h19: res = {1'b1, 4'h4};
      7'h12: res = {1'b1, 4'h5};
      7'h02: res = {1'b1, 4'h6};
      7'h78: res = {1'b1, 4'h7};
      7'h00: res = {1'b1, 4'h8};
      7'h10: res = {1'b1, 4'h9};
      7'h08: res = {1'b1, 4'hA};
      7'h03: res = {1'b1, 4'hB};
      7'h46: res = {1'b1, 4'hC};
      7'h21: res = {1'b1, 4'hD};
      7'h06: res = {1'b1, 4'hE};
      7'h0E: res = {1'b1, 4'hF};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [SEG_W-1:0]  sync_q [SYNC_STAGES];
  logic [SEG_W-1:0]  synced_c;
  logic [SEG_W-1:0]  cand_q;
  logic [SEG_W-1:0]  cand_c;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_c;
  logic [SEG_W-1:0]  acc_q;
  logic              accept_c;
  logic [DIG_W:0]    dec_c;
  logic              dec_hit_c;
  logic [DIG_W-1:0]  dec_digit_c;
  logic              blank_c;
  logic [CNT_W-1:0]  gap_q;
  logic [CNT_W-1:0]  gap_inc_c;
  state_t            state_q;

  // Synchronizer chain; resets to blank so reset never looks like a digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= BLANK;
      end
    end else begin
      sync_q[0] <= seg_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced_c = sync_q[SYNC_STAGES-1];

  // Stability filter: accept fires on the cycle the counter reaches its
  // terminal value, and only for a pattern different from the last accepted.
  always_comb begin
    cand_c   = cand_q;
    stab_c   = stab_q;
    if (synced_c != cand_q) begin
      cand_c = synced_c;
      stab_c = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_c = stab_q + STAB_W'(1);
    end
    accept_c = (stab_c == STAB_MAX) && (cand_c != acc_q);
  end

  assign dec_c       = decode(cand_c);
  assign dec_hit_c   = dec_c[DIG_W];
  assign dec_digit_c = dec_c[DIG_W-1:0];
  assign blank_c     = (cand_c == BLANK);
  assign gap_inc_c   = (gap_q == '1) ? gap_q : gap_q + CNT_W'(1);

  // Candidate, stability count and accepted-pattern registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= BLANK;
      stab_q <= '0;
      acc_q  <= BLANK;
    end else begin
      cand_q <= cand_c;
      stab_q <= stab_c;
      if (accept_c) begin
        acc_q <= cand_c;
      end
    end
  end

  // Cycles since the last accept of any kind; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (accept_c) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_inc_c;
    end
  end

  // Tracking FSM with registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      locked      <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      interval    <= '0;
    end else begin
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      if (accept_c) begin
        if (dec_hit_c) begin
          digit       <= dec_digit_c;
          digit_valid <= 1'b1;
          if (state_q == TRACK) begin
            // gap_inc_c is gap+1 with saturation, i.e. the interval.
            interval <= gap_inc_c;
            seq_err  <= (dec_digit_c != DIG_W'(digit + DIG_W'(1)));
          end
          state_q <= TRACK;
          locked  <= 1'b1;
        end else begin
          pattern_err <= !blank_c;
          state_q     <= IDLE;
          locked      <= 1'b0;
        end
      end
    end
  end

`ifdef SEG7_MON_HIST_EN
  logic [HIST_W-1:0] hist_q [NDIG];

  // Per-digit saturating counts, bumped on each registered digit_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        hist_q[i] <= '0;
      end
      hist_cnt <= '0;
    end else begin
      if (digit_valid && (hist_q[digit] != '1)) begin
        hist_q[digit] <= hist_q[digit] + HIST_W'(1);
      end
      hist_cnt <= hist_q[hist_sel];
    end
  end
`endif

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: directed and random segment sequences checked
// cycle by cycle against a run-based reference model of the display rules.
module tb_seg7_monitor;

  localparam int unsigned SYNC = 2;
  localparam int unsigned STAB = 4;
  localparam int unsigned CW   = 32;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic [6:0]    seg_in = 7'h7F;
  logic [3:0]    digit;
  logic          digit_valid;
  logic          pattern_err;
  logic          seq_err;
  logic [CW-1:0] interval;
  logic          locked;
`ifdef SEG7_MON_HIST_EN
  logic [3:0]    hist_sel = 4'h0;
  logic [15:0]   hist_cnt;
`endif

  seg7_monitor #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .digit      (digit),
    .digit_valid(digit_valid),
    .pattern_err(pattern_err),
    .seq_err    (seq_err),
    .interval   (interval),
    .locked     (locked)
`ifdef SEG7_MON_HIST_EN
    ,
    .hist_sel   (hist_sel),
    .hist_cnt   (hist_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   e;
    logic          v;
    logic          pe;
    logic          se;
    logic [3:0]    d;
    logic [CW-1:0] iv;
    logic          lk;
  } ev_t;

  ev_t evq[$];

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned edge_cnt = 0;

  // Model: current run of identical seg_in values, and the scheduled outcome.
  logic [6:0]    run_val;
  int unsigned   run_start;
  int unsigned   run_len;
  logic          run_done;
  logic [6:0]    m_acc;
  logic [3:0]    m_digit;
  logic          m_locked;
  logic [CW-1:0] m_interval;
  int unsigned   m_last_acc;
  int unsigned   hist_m [16];

  // Expected output state as of the current edge.
  logic [3:0]    c_dig;
  logic [CW-1:0] c_iv;
  logic          c_lk;

  int unsigned sweep_dv;
  int unsigned sweep_se;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic logic [4:0] lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] == p) return {1'b1, 4'(i)};
    end
    return 5'h0;
  endfunction

  task automatic model_reset();
    evq.delete();
    run_val    = 7'h7F;
    run_start  = 0;
    run_len    = 1000;
    run_done   = 1'b1;
    m_acc      = 7'h7F;
    m_digit    = 4'h0;
    m_locked   = 1'b0;
    m_interval = '0;
    m_last_acc = 0;
    c_dig      = 4'h0;
    c_iv       = '0;
    c_lk       = 1'b0;
    for (int i = 0; i < 16; i++) hist_m[i] = 0;
  endtask

  task automatic schedule(input logic [6:0] v, input int unsigned e);
    ev_t ev;
    logic [4:0] lk;
    lk    = lookup(v);
    ev.e  = e;
    ev.v  = lk[4];
    ev.pe = !lk[4] && (v != 7'h7F);
    ev.se = lk[4] && m_locked && (lk[3:0] != 4'(m_digit + 4'd1));
    ev.iv = (lk[4] && m_locked) ? CW'(e - m_last_acc) : m_interval;
    if (lk[4]) begin
      m_digit  = lk[3:0];
      m_locked = 1'b1;
    end else begin
      m_locked = 1'b0;
    end
    m_interval = ev.iv;
    m_last_acc = e;
    m_acc      = v;
    ev.d  = m_digit;
    ev.lk = m_locked;
    evq.push_back(ev);
  endtask

  // A run of one value lasting STAB sampled edges is accepted (if new)
  // SYNC+STAB-1 edges after its first sampling edge.
  task automatic model_seg(input logic [6:0] v, input int unsigned n);
    if (v == run_val) begin
      run_len += n;
    end else begin
      run_val   = v;
      run_start = edge_cnt + 1;
      run_len   = n;
      run_done  = 1'b0;
    end
    if (!run_done && run_len >= STAB) begin
      run_done = 1'b1;
      if (v != m_acc) schedule(v, run_start + SYNC + STAB - 1);
    end
  endtask

  task automatic step();
    ev_t  ev;
    logic e_dv, e_pe, e_se;
    @(posedge clk);
    #1;
    edge_cnt++;
    e_dv = 1'b0;
    e_pe = 1'b0;
    e_se = 1'b0;
    if (evq.size() != 0 && evq[0].e == edge_cnt) begin
      ev    = evq.pop_front();
      e_dv  = ev.v;
      e_pe  = ev.pe;
      e_se  = ev.se;
      c_dig = ev.d;
      c_iv  = ev.iv;
      c_lk  = ev.lk;
      if (ev.v) hist_m[ev.d]++;
    end
    chk("digit_valid", 32'(digit_valid), 32'(e_dv));
    chk("pattern_err", 32'(pattern_err), 32'(e_pe));
    chk("seq_err",     32'(seq_err),     32'(e_se));
    chk("digit",       32'(digit),       32'(c_dig));
    chk("interval",    interval,         c_iv);
    chk("locked",      32'(locked),      32'(c_lk));
    if (digit_valid) sweep_dv++;
    if (seq_err) sweep_se++;
  endtask

  task automatic drive(input logic [6:0] v, input int unsigned n);
    model_seg(v, n);
    seg_in = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    seg_in = 7'h7F;
    #1;
    chk("rst_digit",       32'(digit),       32'h0);
    chk("rst_digit_valid", 32'(digit_valid), 32'h0);
    chk("rst_pattern_err", 32'(pattern_err), 32'h0);
    chk("rst_seq_err",     32'(seq_err),     32'h0);
    chk("rst_interval",    interval,         32'h0);
    chk("rst_locked",      32'(locked),      32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] v;
    int unsigned r;
    sweep_dv = 0;
    sweep_se = 0;

    do_reset();
    drive(7'h7F, 20);

    // First digit: pulse on the 6th edge, from IDLE so no seq_err.
    drive(7'h40, 6);
    chk("lat6_valid", 32'(digit_valid), 32'h1);
    chk("lat6_lock",  32'(locked),      32'h1);

    drive(7'h40, 100);
    drive(7'h79, 100);
    drive(7'h24, 100);
    drive(7'h19, 20);                       // 2 -> 4 : seq_err
    drive(7'h79, 20);
    drive(7'h00, 3);                        // short glitch, ignored
    drive(7'h79, 20);
    chk("glitch_digit", 32'(digit), 32'h1);
    drive(7'h7F, 10);
    drive(7'h55, 10);
    chk("perr_unlock", 32'(locked), 32'h0);

    // Random segments: mostly in-sequence digits plus glitches, blanks, junk.
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r < 4)      v = tbl[4'(m_digit + 4'd1)];
      else if (r < 6) v = tbl[$urandom_range(0, 15)];
      else if (r < 8) v = 7'h7F;
      else            v = 7'($urandom_range(0, 127));
      drive(v, $urandom_range(1, 12));
    end

    // Full sweep 0..F then 0.
    drive(7'h7F, 10);
    sweep_dv = 0;
    sweep_se = 0;
    for (int i = 0; i < 16; i++) drive(tbl[i], 8);
    drive(tbl[0], 8);
    chk("sweep_pulses", sweep_dv, 17);
    chk("sweep_seqerr", sweep_se, 0);

    // Reset in the middle of a sweep.
    drive(7'h7F, 10);
    for (int i = 0; i < 6; i++) drive(tbl[i], 8);
    drive(tbl[6], 3);
    do_reset();
    drive(7'h7F, 5);
    for (int i = 0; i < 4; i++) drive(tbl[i], 8);
    drive(7'h7F, 10);

`ifdef SEG7_MON_HIST_EN
    for (int i = 0; i < 16; i++) begin
      hist_sel = 4'(i);
      model_seg(seg_in, 2);
      step();
      step();
      chk("hist_cnt", 32'(hist_cnt), hist_m[i]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
